mem_port_arbiter: RTL and testbench

//  Shares the single MemReadWrite port between three requesters:
//    0 = instruction fetch, 1 = data load/store, 2 = debug/loader.

---
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one MemReadWrite port between fetch, load/store and debug.
// One access in flight; fixed read latency hidden behind a req/gnt/done handshake.
module mem_port_arbiter #(
    parameter int AW     = 16,
    parameter int DW     = 32,
    parameter int RD_LAT = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      req,
    input  logic [2:0]      we,
    input  logic [3*AW-1:0] addr,
    input  logic [3*DW-1:0] wdata,
    output logic [2:0]      gnt,
    output logic [2:0]      done,
    output logic [DW-1:0]   rdata,
    output logic            busy,
    output logic [1:0]      owner,
    output logic            mem_en,
    output logic            mem_ren,
    output logic            mem_wen,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_din,
    input  logic [DW-1:0]   mem_dout
);

    typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, DONE} state_t;

    localparam logic [3:0] LAT_M1 = 4'(RD_LAT - 1);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [1:0]    owner_q, owner_d;
    logic [2:0]    gnt_q, gnt_d;
    logic [2:0]    done_q, done_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          busy_q, busy_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_ren_q, mem_ren_d;
    logic          mem_wen_q, mem_wen_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_din_q, mem_din_d;
    logic [1:0]    win;

    // Scan order starts just after the last winner; owner_q doubles as the rr pointer.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] c0, c1, c2;
        case (last)
            2'd0:    begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
            2'd1:    begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
            default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
        endcase
        if (r[c0]) return c0;
        if (r[c1]) return c1;
        return c2;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] i);
        return 3'b001 << i;
    endfunction

    always_comb begin
        win        = rr_pick(req, owner_q);
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        gnt_d      = 3'b000;
        done_d     = 3'b000;
        rdata_d    = rdata_q;
        mem_en_d   = mem_en_q;
        mem_ren_d  = mem_ren_q;
        mem_wen_d  = mem_wen_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        case (state_q)
            IDLE: begin
                if (req != 3'b000) begin
                    state_d    = ISSUE;
                    owner_d    = win;
                    gnt_d      = onehot(win);
                    mem_en_d   = 1'b1;
                    mem_ren_d  = ~we[win];
                    mem_wen_d  = we[win];
                    mem_addr_d = addr[win*AW +: AW];
                    mem_din_d  = we[win] ? wdata[win*DW +: DW] : '0;
                end
            end
            ISSUE: begin
                if (mem_wen_q) begin
                    state_d   = DONE;
                    done_d    = onehot(owner_q);
                    mem_en_d  = 1'b0;
                    mem_ren_d = 1'b0;
                    mem_wen_d = 1'b0;
                end else begin
                    state_d = RWAIT;
                    cnt_d   = LAT_M1;
                end
            end
            RWAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d   = DONE;
                    done_d    = onehot(owner_q);
                    rdata_d   = mem_dout;
                    mem_en_d  = 1'b0;
                    mem_ren_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            owner_q    <= 2'd2;
            gnt_q      <= 3'b000;
            done_q     <= 3'b000;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_ren_q  <= 1'b0;
            mem_wen_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            mem_en_q   <= mem_en_d;
            mem_ren_q  <= mem_ren_d;
            mem_wen_q  <= mem_wen_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign rdata    = rdata_q;
    assign busy     = busy_q;
    assign owner    = owner_q;
    assign mem_en   = mem_en_q;
    assign mem_ren  = mem_ren_q;
    assign mem_wen  = mem_wen_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: RD_LAT=3 main instance plus an RD_LAT=5 instance.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = '0, we = '0;
    logic [47:0] addr = '0;
    logic [95:0] wdata = '0;
    logic [2:0]  gnt, done;
    logic [31:0] rdata, mem_din, mem_dout;
    logic        busy, mem_en, mem_ren, mem_wen;
    logic [1:0]  owner;
    logic [15:0] mem_addr;

    logic [2:0]  req5 = '0, we5 = '0;
    logic [47:0] addr5 = '0;
    logic [95:0] wdata5 = '0;
    logic [2:0]  gnt5, done5;
    logic [31:0] rdata5, mem_din5, mem_dout5;
    logic        busy5, mem_en5, mem_ren5, mem_wen5;
    logic [1:0]  owner5;
    logic [15:0] mem_addr5;

    logic [31:0] mem [0:65535];
    int rcnt = 0, rcnt5 = 0;

    typedef struct {int idx; bit rd; logic [31:0] data; int lat;} txn_t;
    txn_t exp_q[$];
    int   exp_gnt[$];
    int   repost[3];
    int   n_tests = 0, n_fail = 0;
    int   cyc = 0, gnt_cyc = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(16), .DW(32), .RD_LAT(3)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .done(done), .rdata(rdata), .busy(busy), .owner(owner),
        .mem_en(mem_en), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    mem_port_arbiter #(.AW(16), .DW(32), .RD_LAT(5)) dut5 (
        .clk(clk), .rst(rst), .req(req5), .we(we5), .addr(addr5), .wdata(wdata5),
        .gnt(gnt5), .done(done5), .rdata(rdata5), .busy(busy5), .owner(owner5),
        .mem_en(mem_en5), .mem_ren(mem_ren5), .mem_wen(mem_wen5),
        .mem_addr(mem_addr5), .mem_din(mem_din5), .mem_dout(mem_dout5)
    );

    // Memory model: read data only becomes valid after RD_LAT cycles of en/ren.
    assign mem_dout  = (rcnt  >= 3) ? mem[mem_addr]  : 32'hBAD0BAD0;
    assign mem_dout5 = (rcnt5 >= 5) ? mem[mem_addr5] : 32'hBAD0BAD0;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        mem[16'h0010] = 32'hDEADBEEF;
        mem[16'h0200] = 32'hA5A50002;
        forever begin
            @(posedge clk);
            if (mem_en && mem_wen) mem[mem_addr] <= mem_din;
            rcnt  <= (mem_en  && mem_ren)  ? rcnt  + 1 : 0;
            rcnt5 <= (mem_en5 && mem_ren5) ? rcnt5 + 1 : 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic expect_txn(input int k, input bit rd, input logic [31:0] d);
        txn_t t;
        t.idx = k; t.rd = rd; t.data = d; t.lat = rd ? 4 : 1;
        exp_gnt.push_back(k);
        exp_q.push_back(t);
    endtask

    task automatic set_req(input int k, input bit w, input logic [15:0] a, input logic [31:0] d);
        we[k] = w;
        addr[k*16 +: 16] = a;
        wdata[k*32 +: 32] = d;
        req[k] = 1'b1;
    endtask

    // Drives requesters until ndone completions; each done drops req[k] unless a re-post is owed.
    task automatic run(input int ndone, output int first_gnt, output int wen_cyc);
        int got = 0;
        first_gnt = -1;
        wen_cyc = 0;
        for (int c = 1; c <= 2000 && got < ndone; c++) begin
            @(negedge clk);
            if (gnt != 3'b000 && first_gnt < 0) first_gnt = c;
            if (mem_wen) wen_cyc++;
            if (done != 3'b000) begin
                got++;
                for (int k = 0; k < 3; k++) begin
                    if (done[k]) begin
                        if (repost[k] > 0) repost[k]--;
                        else req[k] = 1'b0;
                    end
                end
            end
        end
        if (got < ndone) chk("run_timeout", got, ndone);
    endtask

    // Monitor: pops expectations whenever gnt or done is presented.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (gnt != 3'b000) begin
                chk("gnt_onehot", $onehot(gnt), 1);
                if (exp_gnt.size() == 0) begin
                    chk("gnt_unexpected", gnt, 3'b000);
                end else begin
                    chk("gnt_order", gnt, 3'b001 << exp_gnt.pop_front());
                end
                gnt_cyc = cyc;
            end
            if (done != 3'b000) begin
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", done, 3'b000);
                end else begin
                    txn_t t;
                    t = exp_q.pop_front();
                    chk("done_onehot", $onehot(done), 1);
                    chk("done_idx", done, 3'b001 << t.idx);
                    chk("done_latency", cyc - gnt_cyc, t.lat);
                    if (t.rd) chk("rdata", rdata, t.data);
                end
            end
        end
    end

    initial begin
        int fg, wc, g5, d5, n;
        repost = '{0, 0, 0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 2);
        chk("rst_mem_ctl", {mem_en, mem_ren, mem_wen}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_din", mem_din, 0);

        // Single read by fetch
        expect_txn(0, 1, 32'hDEADBEEF);
        set_req(0, 0, 16'h0010, 32'h0);
        run(1, fg, wc);
        chk("t1_req_to_gnt", fg, 1);

        // Single write by load/store, then read it back
        expect_txn(1, 0, 32'h0);
        set_req(1, 1, 16'h0100, 32'h12345678);
        run(1, fg, wc);
        chk("t2_wen_cycles", wc, 1);
        expect_txn(1, 1, 32'h12345678);
        set_req(1, 0, 16'h0100, 32'h0);
        run(1, fg, wc);

        // From reset, all three requesting, two accesses each
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repost = '{1, 1, 1};
        for (int r = 0; r < 2; r++) begin
            expect_txn(0, 1, 32'hDEADBEEF);
            expect_txn(1, 1, 32'h12345678);
            expect_txn(2, 1, 32'hA5A50002);
        end
        set_req(0, 0, 16'h0010, 32'h0);
        set_req(1, 0, 16'h0100, 32'h0);
        set_req(2, 0, 16'h0200, 32'h0);
        run(6, fg, wc);
        chk("t3_owner", owner, 2);

        // Requester 1 just served, then all request; 2 leaves after one access
        expect_txn(1, 1, 32'h12345678);
        set_req(1, 0, 16'h0100, 32'h0);
        run(1, fg, wc);
        repost = '{9, 8, 0};
        expect_txn(2, 1, 32'hA5A50002);
        for (int i = 0; i < 19; i++) begin
            if (i % 2 == 0) expect_txn(0, 0, 32'h0);
            else expect_txn(1, 1, 32'hDEADBEEF);
        end
        set_req(0, 1, 16'h0300, 32'hC0DE0000);
        set_req(1, 0, 16'h0010, 32'h0);
        set_req(2, 0, 16'h0200, 32'h0);
        run(20, fg, wc);
        expect_txn(2, 1, 32'hC0DE0000);
        set_req(2, 0, 16'h0300, 32'h0);
        run(1, fg, wc);

        // Reset pulsed mid-RWAIT: the pending done must never appear
        exp_gnt.push_back(1);
        set_req(1, 0, 16'h0100, 32'h0);
        n = 0;
        while (gnt[1] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t5_gnt_seen", gnt[1], 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        req = 3'b000;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_mem_en", mem_en, 0);
        chk("t5_owner", owner, 2);
        repeat (6) @(negedge clk);
        expect_txn(2, 1, 32'hA5A50002);
        set_req(2, 0, 16'h0200, 32'h0);
        run(1, fg, wc);

        // RD_LAT=5 instance: single read
        g5 = -1;
        d5 = -1;
        addr5[15:0] = 16'h0010;
        req5 = 3'b001;
        for (int c = 1; c <= 50 && d5 < 0; c++) begin
            @(negedge clk);
            if (gnt5[0]) g5 = c;
            if (done5 != 3'b000) begin
                d5 = c;
                chk("t6_done_idx", done5, 3'b001);
                chk("t6_rdata", rdata5, 32'hDEADBEEF);
                req5 = 3'b000;
            end
        end
        chk("t6_latency", d5 - g5, 6);

        repeat (5) @(negedge clk);
        chk("sb_done_drained", exp_q.size(), 0);
        chk("sb_gnt_drained", exp_gnt.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
